cpu_mem_sequencer: RTL

- Host-side controller that sequences the 5-stage CPU through a complete program run.
- Boot phase: loads instruction memory through addr_ext/wen_ext/wdata_ext, then loads data memory through addr_ext_2/wen_ext_2/wdata_ext_2.
- Run phase: asserts the CPU enable for a fixed cycle budget.
- Readback phase: streams data-memory contents back to the host over a valid/ready channel.
- Sits between the testbench/host interface and the CPU external memory ports.

---
 rtl/cpu_mem_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cpu_mem_sequencer.sv
// Host-side sequencer for the 5-stage CPU: boots instruction and data memory,
// runs the core for a fixed cycle budget, then streams data memory back.
module cpu_mem_sequencer #(
  parameter int IMEM_WORDS = 128,
  parameter int DMEM_WORDS = 32,
  parameter int RUN_CYCLES = 1024,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic        host_valid,
  input  logic [63:0] host_data,
  output logic        host_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        cpu_enable,
  output logic        res_valid,
  output logic [63:0] res_data,
  input  logic        res_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, LOAD_I, LOAD_D, RUN, RD_REQ, RD_WAIT, RESULT, DONE
  } state_t;

  localparam logic [CNT_W-1:0] I_LAST = CNT_W'(IMEM_WORDS - 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DMEM_WORDS - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(RUN_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] ccnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= IDLE;
      wcnt     <= '0;
      ccnt     <= '0;
      res_data <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= LOAD_I;
            wcnt  <= '0;
          end
        end
        LOAD_I: begin
          if (host_valid) begin
            if (wcnt == I_LAST) begin
              state <= LOAD_D;
              wcnt  <= '0;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        LOAD_D: begin
          if (host_valid) begin
            if (wcnt == D_LAST) begin
              state <= RUN;
              ccnt  <= '0;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        RUN: begin
          ccnt <= ccnt + 1'b1;
          if (ccnt == R_LAST) begin
            state <= RD_REQ;
            wcnt  <= '0;
          end
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          // Memory returns the word one cycle after the request.
          res_data <= rdata_ext_2;
          state    <= RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            wcnt  <= wcnt + 1'b1;
            state <= (wcnt == D_LAST) ? DONE : RD_REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ren_ext = 1'b0;

  // Memory ports decode straight from state so an async reset silences them
  // (and cpu_enable) in the same cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    host_ready  = 1'b0;
    addr_ext    = '0;
    wen_ext     = 1'b0;
    wdata_ext   = '0;
    addr_ext_2  = '0;
    wen_ext_2   = 1'b0;
    ren_ext_2   = 1'b0;
    wdata_ext_2 = '0;
    cpu_enable  = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      IDLE: busy = 1'b0;
      LOAD_I: begin
        host_ready = 1'b1;
        addr_ext   = 64'(wcnt) << 2;
        wdata_ext  = host_data[31:0];
        wen_ext    = host_valid;
      end
      LOAD_D: begin
        host_ready  = 1'b1;
        addr_ext_2  = 64'(wcnt) << 3;
        wdata_ext_2 = host_data;
        wen_ext_2   = host_valid;
      end
      RUN: cpu_enable = 1'b1;
      RD_REQ: begin
        ren_ext_2  = 1'b1;
        addr_ext_2 = 64'(wcnt) << 3;
      end
      RESULT: res_valid = 1'b1;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
